// File: rtl/tree_reduce_sequencer.sv
// Streams a long vector through the shared pipelined adder tree one word per cycle,
// accumulating the per-chunk tree sums into a wide tagged result.
module tree_reduce_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUTS = 8,
    parameter int TREE_LAT   = $clog2(NUM_INPUTS),
    parameter int LEN_W      = 12,
    parameter int ADDR_W     = 10,
    parameter int ACC_W      = 32,
    parameter int TAG_W      = 4
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [ADDR_W-1:0]                cmd_addr,
    input  logic [LEN_W-1:0]                 cmd_len,
    input  logic [TAG_W-1:0]                 cmd_tag,
    output logic                             mem_rd_en,
    output logic [ADDR_W-1:0]                mem_rd_addr,
    input  logic [DATA_WIDTH*NUM_INPUTS-1:0] mem_rd_data,
    output logic [DATA_WIDTH*NUM_INPUTS-1:0] tree_in_data,
    output logic [$clog2(NUM_INPUTS):0]      tree_num_valid,
    output logic                             tree_out_ready,
    input  logic [DATA_WIDTH-1:0]            tree_sum,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [ACC_W-1:0]                 res_sum,
    output logic [TAG_W-1:0]                 res_tag,
    output logic                             busy
);
    localparam int LOG  = $clog2(NUM_INPUTS);
    localparam int NV_W = LOG + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  chunk_k;
    logic [TREE_LAT:0] vpipe;
    logic [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]  last_chunk;
    logic [NV_W-1:0]   last_lanes;
    logic [NV_W-1:0]   cur_lanes;
    logic              last_issue;

    assign tree_in_data   = mem_rd_data;
    assign tree_out_ready = 1'b1;
    assign res_sum        = acc;

    // Index of the final chunk and its lane count, derived from the latched length.
    always_comb begin
        last_chunk = (len_q - LEN_W'(1)) >> LOG;
        last_lanes = (len_q[LOG-1:0] == '0) ? NV_W'(NUM_INPUTS) : {1'b0, len_q[LOG-1:0]};
        last_issue = (chunk_k == last_chunk);
        cur_lanes  = last_issue ? last_lanes : NV_W'(NUM_INPUTS);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            len_q          <= '0;
            chunk_k        <= '0;
            vpipe          <= '0;
            acc            <= '0;
            res_tag        <= '0;
            mem_rd_en      <= 1'b0;
            mem_rd_addr    <= '0;
            tree_num_valid <= '0;
            cmd_ready      <= 1'b1;
            res_valid      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            // Each issued read is tagged so its tree sum is picked up TREE_LAT+1 cycles later.
            vpipe          <= {vpipe[TREE_LAT-1:0], mem_rd_en};
            tree_num_valid <= mem_rd_en ? cur_lanes : '0;
            if (vpipe[TREE_LAT]) begin
                acc <= acc + ACC_W'(tree_sum);
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        len_q       <= cmd_len;
                        res_tag     <= cmd_tag;
                        acc         <= '0;
                        chunk_k     <= '0;
                        mem_rd_addr <= cmd_addr;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        if (cmd_len != '0) begin
                            state     <= ISSUE;
                            mem_rd_en <= 1'b1;
                        end else begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (last_issue) begin
                        mem_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        chunk_k     <= chunk_k + LEN_W'(1);
                        mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // Leave once the final tagged sum is being absorbed this cycle.
                    if (vpipe[TREE_LAT-1:0] == '0) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
